phase_seq_mon: RTL

Receive-side monitor for the 8-phase one-hot sequence produced by the team's Johnson-counter phase generator. Samples the one-hot phase bus every CLK, encodes it to a 3-bit index, checks that the sequence only holds or advances by one (mod 8), acquires lock, counts completed laps and latches the first sequence fault. Sits downstream of the phase generator in the flow-control datapath; its LOCK/ERR outputs gate the consumers of the phase bus.

---
 rtl/phase_seq_mon.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/phase_seq_mon.sv
// phase_seq_mon: receive-side monitor for the 8-phase one-hot sequence.
// Encodes PH to an index, checks hold/+1 progression, acquires lock after
// LOCK_N consecutive advances, counts 7->0 laps while locked and latches the
// first fault cause.
// Optional feature: define STRICT_ADV_EN to require PH motion to follow the
// registered enable (advance when EN_q=1, hold when EN_q=0).
module phase_seq_mon #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned LOCK_N = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [7:0]       PH,
  input  logic             ERR_CLR,
  output logic [2:0]       IDX,
  output logic             VALID,
  output logic             LOCK,
  output logic             ERR,
  output logic [1:0]       ERR_CODE,
  output logic [CNT_W-1:0] LAPS
);

  typedef enum logic [1:0] {UNLOCK, LOCKED, FAULT} state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_N);
  localparam logic [1:0] C_NONE   = 2'b00;
  localparam logic [1:0] C_HOT    = 2'b01;
  localparam logic [1:0] C_SKIP   = 2'b10;

  state_t           state, state_n;
  logic [3:0]       run_cnt, run_n;
  logic             have_prev, have_prev_n;
  logic [2:0]       idx_n;
  logic             valid_n;
  logic             err_n;
  logic [1:0]       code_n;
  logic [CNT_W-1:0] laps_n;

  logic             one_hot;
  logic [2:0]       enc;
  logic             is_hold;
  logic             is_adv;
  logic [1:0]       cause;
  logic             adv_ok;

`ifdef STRICT_ADV_EN
  logic             en_q;

  // Registered copy of the generator enable: it describes the motion
  // expected in the sample taken on the following edge.
  always_ff @(posedge CLK) begin
    if (RST) en_q <= 1'b0;
    else     en_q <= EN;
  end
`else
  logic             unused_en;
  assign unused_en = EN;
`endif

  // Encode the sample; IDX doubles as the stored previous valid index.
  always_comb begin
    one_hot = $onehot(PH);
    enc     = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (PH[i]) enc = 3'(i);
    end
    is_hold = (enc == IDX);
    is_adv  = (enc == IDX + 3'd1);
  end

  // Fault classification in priority order: not one-hot, skip, strict.
  always_comb begin
    cause = C_NONE;
    if (!one_hot) begin
      cause = C_HOT;
    end else if (have_prev && !(is_hold || is_adv)) begin
      cause = C_SKIP;
    end
`ifdef STRICT_ADV_EN
    else if (have_prev && (en_q ? !is_adv : !is_hold)) begin
      cause = 2'b11;
    end
`endif
    adv_ok = one_hot && have_prev && is_adv && (cause == C_NONE);
  end

  // Next-state and next-output logic; clear overrides any same-cycle fault.
  always_comb begin
    state_n     = state;
    run_n       = run_cnt;
    have_prev_n = have_prev | one_hot;
    idx_n       = one_hot ? enc : IDX;
    valid_n     = one_hot;
    err_n       = ERR;
    code_n      = ERR_CODE;
    laps_n      = LAPS;
    if (ERR_CLR) begin
      state_n     = UNLOCK;
      run_n       = '0;
      have_prev_n = 1'b0;
      err_n       = 1'b0;
      code_n      = C_NONE;
    end else begin
      case (state)
        UNLOCK: begin
          if (cause != C_NONE) begin
            run_n = '0;
          end else if (adv_ok && (run_cnt < LOCK_TGT)) begin
            run_n = run_cnt + 4'd1;
          end
          if (run_n == LOCK_TGT) state_n = LOCKED;
        end
        LOCKED: begin
          if (cause != C_NONE) begin
            state_n = FAULT;
            err_n   = 1'b1;
            code_n  = cause;
          end else if (adv_ok && (enc == 3'd0)) begin
            laps_n = LAPS + CNT_W'(1);
          end
        end
        FAULT:   ;
        default: state_n = UNLOCK;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= UNLOCK;
      run_cnt   <= '0;
      have_prev <= 1'b0;
      IDX       <= '0;
      VALID     <= 1'b0;
      ERR       <= 1'b0;
      ERR_CODE  <= '0;
      LAPS      <= '0;
    end else begin
      state     <= state_n;
      run_cnt   <= run_n;
      have_prev <= have_prev_n;
      IDX       <= idx_n;
      VALID     <= valid_n;
      ERR       <= err_n;
      ERR_CODE  <= code_n;
      LAPS      <= laps_n;
    end
  end

  assign LOCK = (state == LOCKED);

endmodule
